// File: rtl/fir3_par_sched.sv
// Sequencer for a 3-lane parallel FIR: coefficient reload, 3-sample block packing, start pulses, result re-serialisation.
// Latency: fir_start 1 cycle after a block's 3rd sample; results enter the out buffer 2 cycles after the next start.
// Backpressure: s_ready drops on a block's 3rd sample while results are pending. Optional flush port: FIR3_FLUSH_EN.
module fir3_par_sched #(
    parameter int N  = 99,
    parameter int DW = 16,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic          cfg_valid,
    input  logic [DW-1:0] cfg_data,
    output logic          cfg_ready,
    output logic          cfg_done,
`ifdef FIR3_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [AW-1:0] m_data,
    input  logic          m_ready,
    output logic          fir_load,
    output logic [DW-1:0] fir_coeff,
    output logic          fir_start,
    output logic [DW-1:0] fir_x0,
    output logic [DW-1:0] fir_x1,
    output logic [DW-1:0] fir_x2,
    input  logic [AW-1:0] fir_y0,
    input  logic [AW-1:0] fir_y1,
    input  logic [AW-1:0] fir_y2
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic          primed_q, primed_d;
    logic          start_q, start_d;
    logic          drain_q, drain_d;
    logic          cap_q, cap_d;
    logic          flreq_q, flreq_d;
    logic          cfg_done_q, cfg_done_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [DW-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic [AW-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic          idle;
    logic          flush_in;

`ifdef FIR3_FLUSH_EN
    assign flush_in = flush;
`else
    assign flush_in = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        primed_d   = primed_q;
        start_d    = 1'b0;
        drain_d    = 1'b0;
        cap_d      = 1'b0;
        flreq_d    = flreq_q;
        cfg_done_d = 1'b0;
        wcnt_d     = wcnt_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        b2_d       = b2_q;
        bcnt_d     = bcnt_q;
        s_ready    = 1'b0;
        cfg_ready  = 1'b0;
        fir_load   = 1'b0;
        fir_coeff  = '0;

        idle = (bcnt_q == 2'd0) && !start_q && !cap_q;

        // The FIR answers a start with the previous block's result; keep it only if that block was real.
        if (start_q) begin
            cap_d    = primed_q;
            primed_d = !drain_q;
        end

        if (cap_q) begin
            b0_d   = fir_y0;
            b1_d   = fir_y1;
            b2_d   = fir_y2;
            bcnt_d = 2'd3;
        end else if ((bcnt_q != 2'd0) && m_ready) begin
            b0_d   = b1_q;
            b1_d   = b2_q;
            b2_d   = '0;
            bcnt_d = bcnt_q - 2'd1;
        end

        case (state_q)
            ST_RUN: begin
                s_ready = !rst && !cfg_start && !flush_in && !flreq_q &&
                          !((col_q == 2'd2) && !idle);
                if (cfg_start) begin
                    col_d    = 2'd0;
                    primed_d = 1'b0;
                    flreq_d  = 1'b0;
                    state_d  = ST_DRAIN;
                end else if (s_valid && s_ready) begin
                    case (col_q)
                        2'd0:    x0_d = s_data;
                        2'd1:    x1_d = s_data;
                        default: x2_d = s_data;
                    endcase
                    if (col_q == 2'd2) begin
                        col_d   = 2'd0;
                        start_d = 1'b1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else if (flreq_q && idle) begin
                    start_d = 1'b1;
                    if (col_q != 2'd0) begin
                        // Zero-pad the partial block; a drain start follows to push its result out.
                        if (col_q == 2'd1) begin
                            x1_d = '0;
                        end
                        x2_d  = '0;
                        col_d = 2'd0;
                    end else begin
                        x0_d    = '0;
                        x1_d    = '0;
                        x2_d    = '0;
                        drain_d = 1'b1;
                        flreq_d = 1'b0;
                    end
                end else if (flush_in && (primed_q || (col_q != 2'd0))) begin
                    flreq_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (idle) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cfg_ready = !rst;
                fir_load  = cfg_valid && !rst;
                if (fir_load) begin
                    fir_coeff = cfg_data;
                    if (wcnt_q == CW'(N - 1)) begin
                        wcnt_d     = '0;
                        cfg_done_d = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            col_q      <= 2'd0;
            primed_q   <= 1'b0;
            start_q    <= 1'b0;
            drain_q    <= 1'b0;
            cap_q      <= 1'b0;
            flreq_q    <= 1'b0;
            cfg_done_q <= 1'b0;
            wcnt_q     <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            bcnt_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            primed_q   <= primed_d;
            start_q    <= start_d;
            drain_q    <= drain_d;
            cap_q      <= cap_d;
            flreq_q    <= flreq_d;
            cfg_done_q <= cfg_done_d;
            wcnt_q     <= wcnt_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            bcnt_q     <= bcnt_d;
        end
    end

    assign cfg_done  = cfg_done_q;
    assign fir_start = start_q;
    assign fir_x0    = x0_q;
    assign fir_x1    = x1_q;
    assign fir_x2    = x2_q;
    assign m_valid   = (bcnt_q != 2'd0);
    assign m_data    = b0_q;

endmodule

// File: tb/tb_fir3_par_sched.sv
// Directed bench for fir3_par_sched (N=6) with a behavioural 3-lane FIR on the fir_* side.
module tb_fir3_par_sched;
    localparam int N  = 6;
    localparam int M  = 2;
    localparam int DW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst, cfg_start, cfg_valid, s_valid, m_ready;
    logic [DW-1:0] cfg_data, s_data;
    logic          cfg_ready, cfg_done, s_ready, m_valid, fir_load, fir_start;
    logic [AW-1:0] m_data, fir_y0, fir_y1, fir_y2;
    logic [DW-1:0] fir_coeff, fir_x0, fir_x1, fir_x2;
`ifdef FIR3_FLUSH_EN
    logic          flush;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir3_par_sched #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done),
`ifdef FIR3_FLUSH_EN
        .flush(flush),
`endif
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .fir_load(fir_load), .fir_coeff(fir_coeff), .fir_start(fir_start),
        .fir_x0(fir_x0), .fir_x1(fir_x1), .fir_x2(fir_x2),
        .fir_y0(fir_y0), .fir_y1(fir_y1), .fir_y2(fir_y2)
    );

    // Behavioural FIR: lane l output = sum_j coef[l*M+j] * x_l(block - j); a start returns the previous block's sum.
    logic signed [DW-1:0] coef [0:N-1];
    logic signed [DW-1:0] hist [0:2][0:M-1];
    logic signed [AW-1:0] res  [0:2];
    int li;

    always @(posedge clk) begin
        if (rst) begin
            li = 0;
            for (int k = 0; k < N; k++) coef[k] = '0;
            for (int l = 0; l < 3; l++) begin
                res[l] = '0;
                for (int j = 0; j < M; j++) hist[l][j] = '0;
            end
            fir_y0 <= '0;
            fir_y1 <= '0;
            fir_y2 <= '0;
        end else begin
            if (fir_load) begin
                coef[li] = fir_coeff;
                li = (li + 1) % N;
            end
            if (fir_start) begin
                fir_y0 <= res[0];
                fir_y1 <= res[1];
                fir_y2 <= res[2];
                for (int l = 0; l < 3; l++) begin
                    for (int j = M - 1; j > 0; j--) hist[l][j] = hist[l][j-1];
                end
                hist[0][0] = fir_x0;
                hist[1][0] = fir_x1;
                hist[2][0] = fir_x2;
                for (int l = 0; l < 3; l++) begin
                    res[l] = '0;
                    for (int j = 0; j < M; j++) res[l] = res[l] + coef[l*M+j] * hist[l][j];
                end
            end
        end
    end

    logic [AW-1:0] out_q [$];
    logic [AW-1:0] exp_q [$];
    logic [DW-1:0] cw [0:5];
    int done_cnt = 0;
    int start_cnt = 0;
    int overlap = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) out_q.push_back(m_data);
            if (cfg_done) done_cnt++;
            if (fir_start) start_cnt++;
            if (fir_load && fir_start) overlap++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [DW-1:0] v);
        logic ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = v;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        chk("sample_accept", ok, 1);
    endtask

    task automatic send_coeff(input logic [DW-1:0] v);
        logic ok;
        ok = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = v;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                ok = 1'b1;
                chk("fir_load_pass", fir_load, 1);
                chk("fir_coeff_pass", fir_coeff, v);
            end
            tick();
        end
        cfg_valid = 1'b0;
        chk("coeff_accept", ok, 1);
    endtask

    task automatic pulse_cfg();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Loads cw[0..5] with a valid gap after the third word, then checks the single done pulse.
    task automatic load_words();
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            send_coeff(cw[i]);
            if (i == 2) begin
                @(negedge clk);
                chk("gap_fir_load", fir_load, 0);
                tick();
            end
        end
        @(negedge clk);
        chk("cfg_done_pulse", cfg_done, 1);
        chk("cfg_ready_after_load", cfg_ready, 0);
        tick();
        @(negedge clk);
        chk("cfg_done_once", cfg_done, 0);
        tick();
        chk("cfg_done_count", done_cnt - d0, 1);
    endtask

    task automatic check_outs(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < 300 && out_q.size() < n; i++) tick();
        repeat (8) tick();
        chk({tag, "_count"}, out_q.size(), n);
        for (int i = 0; i < n && i < out_q.size(); i++) chk({tag, "_word"}, out_q[i], exp_q[i]);
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int hi;
        int stable_err;
        int s0;
        rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
`ifdef FIR3_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) tick();
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_fir_start", fir_start, 0);
        chk("rst_m_data", m_data, 0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("run_s_ready", s_ready, 1);
        tick();

        // A: identity taps on tap 0; first block silent, second start returns block 0.
        cw = '{16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
        pulse_cfg();
        load_words();
        send_sample(16'd10); send_sample(16'd20); send_sample(16'd30);
        repeat (6) tick();
        chk("first_block_silent", out_q.size(), 0);
        send_sample(16'd40); send_sample(16'd50); send_sample(16'd60);
        exp_q = '{32'd10, 32'd20, 32'd30};
        check_outs("blk_identity");

        // B: tap 1 only; history survives reload so the second start returns 40,50,60.
        cw = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1};
        pulse_cfg();
        load_words();
        for (int v = 1; v <= 9; v++) send_sample(16'(v));
        exp_q = '{32'd40, 32'd50, 32'd60, 32'd1, 32'd2, 32'd3};
        check_outs("blk_delay");

        // C: output stalled; 3rd sample of the second block must wait, m_data must hold.
        m_ready = 1'b0;
        for (int v = 10; v <= 14; v++) send_sample(16'(v));
        s_valid = 1'b1;
        s_data  = 16'd15;
        hi = 0;
        stable_err = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_ready) hi++;
            if (m_data !== 32'd4) stable_err++;
            tick();
        end
        s_valid = 1'b0;
        chk("bp_s_ready_low", hi, 0);
        chk("bp_m_data_hold", stable_err, 0);
        @(negedge clk);
        chk("bp_m_valid", m_valid, 1);
        tick();
        m_ready = 1'b1;
        send_sample(16'd15);
        send_sample(16'd16); send_sample(16'd17); send_sample(16'd18);
        exp_q = '{32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12};
        check_outs("bp_stream");

        // D: reload mid-block drops the partial block and the first post-load block is silent.
        s0 = start_cnt;
        send_sample(16'd20); send_sample(16'd21);
        cfg_start = 1'b1;
        s_valid   = 1'b1;
        s_data    = 16'd22;
        @(negedge clk);
        chk("cfg_start_blocks_sample", s_ready, 0);
        tick();
        cfg_start = 1'b0;
        s_valid   = 1'b0;
        cw = '{16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
        load_words();
        for (int v = 30; v <= 35; v++) send_sample(16'(v));
        exp_q = '{32'd30, 32'd31, 32'd32};
        check_outs("reload_partial");
        chk("reload_start_count", start_cnt - s0, 2);

        // E: reset while loading word 3.
        pulse_cfg();
        send_coeff(16'd5); send_coeff(16'd6); send_coeff(16'd7);
        cfg_valid = 1'b1;
        cfg_data  = 16'd8;
        rst       = 1'b1;
        @(negedge clk);
        chk("rst_load_gated", fir_load, 0);
        tick();
        @(negedge clk);
        chk("rstload_m_valid", m_valid, 0);
        chk("rstload_cfg_ready", cfg_ready, 0);
        chk("rstload_fir_start", fir_start, 0);
        chk("rstload_cfg_done", cfg_done, 0);
        chk("rstload_fir_x0", fir_x0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstload_run_cfg_ready", cfg_ready, 0);
        chk("rstload_run_fir_load", fir_load, 0);
        chk("rstload_run_s_ready", s_ready, 1);
        tick();
        cfg_valid = 1'b0;
        tick();

`ifdef FIR3_FLUSH_EN
        // F: flush pads the partial block and drains the last result.
        cw = '{16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
        pulse_cfg();
        load_words();
        send_sample(16'd10); send_sample(16'd20); send_sample(16'd30); send_sample(16'd40);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd0, 32'd0};
        check_outs("flush");
`endif

        chk("load_start_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
